// File: rtl/seq_pkg.sv
// Package for the call/return program sequencer.
// Holds the next-pc source selector enum and the jump-target formation helper.
// Optional feature macro used by the sequencer: SEQ_IRQ_EN.
package seq_pkg;

  typedef enum logic [2:0] {
    NPC_RESET,
    NPC_HOLD,
    NPC_RET,
    NPC_TGT,
    NPC_INC,
    NPC_IRQ
  } npc_sel_t;

  // The jump target is the page number placed in the upper TGT_W bits of the
  // address, with the low (addr_w - tgt_w) bits zero. Callers truncate to ADDR_W.
  function automatic logic [31:0] form_target(input logic [31:0] tgt,
                                              input int          tgt_w,
                                              input int          addr_w);
    return tgt << (addr_w - tgt_w);
  endfunction

endpackage

// File: rtl/seq_return_stack.sv
// Parameterised LIFO return-address stack.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset (clears occupancy only)
//   push  - write din at entry[sp], sp+1 (ignored when full)
//   pop   - sp-1 (ignored when empty)
//   din   - address to push
//   top   - entry[sp-1], or 0 when empty
//   sp    - current occupancy, 0..DEPTH
//   full  - sp == DEPTH
//   empty - sp == 0
// Overflow/underflow are recorded by the parent; this block just refuses the
// operation.
module seq_return_stack
  import seq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int SP_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] top,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  // Indices are only used when in range: writes only when not full, reads
  // only when not empty.
  assign wr_idx  = IDX_W'(sp);
  assign top_idx = IDX_W'(sp - SP_W'(1));
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Storage is not reset; contents above sp are don't-care.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/call_stack_sequencer.sv
// Program sequencer for the nibble-ISA processor with return-address stack.
// Selects the next fetch address (combinational pm_address) from reset vector,
// hold, stack return, jump/call target or increment, and registers it as pc.
// Ports:
//   clk, sync_reset                  - clock and synchronous active-high reset
//   stall                            - freeze fetch, ignore all control
//   jump, conditional_jump, call, ret- control flow requests
//   dont_jump_flag                   - suppresses conditional_jump when 1
//   jump_addr [TGT_W]                - target page
//   pm_address [ADDR_W]              - next fetch address (combinational)
//   pc [ADDR_W]                      - current fetch address
//   from_PS [ADDR_W]                 - top of stack, 0 when empty
//   sp                               - stack occupancy
//   stack_overflow, stack_underflow  - sticky fault flags, cleared by reset
//   irq_req / irq_ack                - level interrupt request / take pulse
// Optional feature macro: SEQ_IRQ_EN (adds irq_req/irq_ack and IRQ entry).
module call_stack_sequencer
  import seq_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          TGT_W       = 4,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned RESET_VEC   = 0,
  parameter int unsigned IRQ_VEC     = 8'hF0,
  parameter int          SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic              stall,
  input  logic              jump,
  input  logic              conditional_jump,
  input  logic              dont_jump_flag,
  input  logic              call,
  input  logic              ret,
  input  logic [TGT_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0] pm_address,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] from_PS,
  output logic [SP_W-1:0]   sp,
  output logic              stack_overflow,
  output logic              stack_underflow
`ifdef SEQ_IRQ_EN
  ,
  input  logic              irq_req,
  output logic              irq_ack
`endif
);

  if (TGT_W > ADDR_W) begin : g_bad_tgt_w
    $error("TGT_W must not exceed ADDR_W");
  end
  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("STACK_DEPTH must be at least 1");
  end
  if ((ADDR_W < 32) && (IRQ_VEC >= (32'd1 << ADDR_W))) begin : g_bad_irq_vec
    $error("IRQ_VEC does not fit in ADDR_W");
  end

  npc_sel_t          sel;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] top;
  logic              full;
  logic              empty;
  logic              push_req;
  logic              pop_req;

  assign pc_inc = pc + ADDR_W'(1);
  assign target = ADDR_W'(form_target(32'(jump_addr), TGT_W, ADDR_W));

`ifdef SEQ_IRQ_EN
  logic in_isr;
  logic irq_take;

  // Any pending control flow defers the interrupt; no nesting.
  assign irq_take = irq_req && !in_isr && !stall && !sync_reset &&
                    !(jump || call || ret || conditional_jump);
`endif

  always_comb begin
    sel = NPC_INC;
    if (sync_reset) begin
      sel = NPC_RESET;
    end else if (stall) begin
      sel = NPC_HOLD;
`ifdef SEQ_IRQ_EN
    end else if (irq_take) begin
      sel = NPC_IRQ;
`endif
    end else if (ret) begin
      sel = NPC_RET;
    end else if (call || jump) begin
      sel = NPC_TGT;
    end else if (conditional_jump && !dont_jump_flag) begin
      sel = NPC_TGT;
    end
  end

  always_comb begin
    pm_address = pc_inc;
    case (sel)
      NPC_RESET: pm_address = ADDR_W'(RESET_VEC);
      NPC_HOLD:  pm_address = pc;
      // A return with nothing on the stack falls through to the next word.
      NPC_RET:   pm_address = empty ? pc_inc : top;
      NPC_TGT:   pm_address = target;
      NPC_IRQ:   pm_address = ADDR_W'(IRQ_VEC);
      default:   pm_address = pc_inc;
    endcase
  end

  // call shares NPC_TGT with jump/conditional_jump; only call pushes.
`ifdef SEQ_IRQ_EN
  assign push_req = ((sel == NPC_TGT) && call) || (sel == NPC_IRQ);
`else
  assign push_req = (sel == NPC_TGT) && call;
`endif
  assign pop_req  = (sel == NPC_RET);

  seq_return_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W),
    .SP_W   (SP_W)
  ) u_stack (
    .clk   (clk),
    .rst   (sync_reset),
    .push  (push_req),
    .pop   (pop_req),
    .din   (pc_inc),
    .top   (top),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  assign from_PS = top;

  // pc follows pm_address unconditionally, so reset lands on RESET_VEC.
  always_ff @(posedge clk) begin
    pc <= pm_address;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      if (push_req && full) begin
        stack_overflow <= 1'b1;
      end
      if (pop_req && empty) begin
        stack_underflow <= 1'b1;
      end
    end
  end

`ifdef SEQ_IRQ_EN
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      in_isr  <= 1'b0;
      irq_ack <= 1'b0;
    end else begin
      irq_ack <= (sel == NPC_IRQ);
      if (sel == NPC_IRQ) begin
        in_isr <= 1'b1;
      end else if (sel == NPC_RET) begin
        in_isr <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: doc/call_stack_sequencer.md
Name: call_stack_sequencer

Overview:
- Next-generation program sequencer for the nibble-ISA microprocessor; drop-in replacement for the current sequencer between instruction decoder and program memory.
- Generalises address width, jump-target width and reset vector.
- Adds a hardware return-address stack (CALL/RET), a fetch stall, and sticky stack-fault flags.
- pm_address is combinational and drives the inverted-clock program memory directly.

Parameters:
- ADDR_W, 8, program-memory address width; pc wraps modulo 2^ADDR_W.
- TGT_W, 4, jump_addr width; must satisfy TGT_W <= ADDR_W.
- STACK_DEPTH, 4, return-stack entries; must be >= 1.
- RESET_VEC, 0, address fetched during and after reset.
- IRQ_VEC, 8'hF0, interrupt entry address; used only with SEQ_IRQ_EN.

Ports:
- clk  in  1  system clock, rising edge.
- sync_reset  in  1  synchronous, active-high reset.
- stall  in  1  hold fetch: pc frozen, all control inputs ignored.
- jump  in  1  unconditional jump.
- conditional_jump  in  1  jump when dont_jump_flag=0.
- dont_jump_flag  in  1  zero flag from the computational unit.
- call  in  1  push return address, then jump.
- ret  in  1  pop return address and branch to it.
- jump_addr  in  TGT_W  target page; target = {jump_addr, (ADDR_W-TGT_W) zeros}.
- pm_address  out  ADDR_W  combinational next fetch address.
- pc  out  ADDR_W  registered current fetch address.
- from_PS  out  ADDR_W  debug: top-of-stack value, 0 when the stack is empty.
- sp  out  $clog2(STACK_DEPTH+1)  current stack occupancy.
- stack_overflow  out  1  sticky flag.
- stack_underflow  out  1  sticky flag.
- irq_req  in  1  level interrupt request (SEQ_IRQ_EN only).
- irq_ack  out  1  one-cycle pulse when the interrupt is taken (SEQ_IRQ_EN only).

Behaviour:
- pm_address priority, highest first; exactly one source is selected:
  1. sync_reset → RESET_VEC.
  2. stall → pc.
  3. ret → top of stack; if sp==0, pc+1 instead.
  4. call or jump → target.
  5. conditional_jump & !dont_jump_flag → target.
  6. Otherwise → pc+1.
- pc <= pm_address on every rising edge, so the pc reset value is RESET_VEC.
- Increment wraps: 2^ADDR_W-1 → 0.
- Push on call: value is pc+1, taken only when the call is selected (not reset, not stall, no ret).
  - If sp==STACK_DEPTH, the push is dropped, the jump is still taken, sp is unchanged, and stack_overflow is set.
- Pop on ret: taken only when the ret is selected.
  - If sp==0, pm_address falls through to pc+1, sp stays 0, and stack_underflow is set.
- Simultaneous events:
  - ret with call: ret wins; no push.
  - call with jump: identical target; push occurs.
  - Any input with stall: no state change at all.
- Reset, including mid-call or mid-ISR: sp=0, flags=0, in_isr=0, irq_ack=0, pc=RESET_VEC. Stack contents are don't-care.
- Sticky flags clear only on sync_reset.
- Latency: pm_address reacts in the same cycle; pc and sp update on the next edge.
- Stack storage is a LIFO array indexed by sp. Top of stack = entry[sp-1].

Optional Feature:
- Macro: SEQ_IRQ_EN.
- Defined:
  - Interrupt is taken when irq_req & !in_isr & !stall & !sync_reset and none of jump/call/ret/conditional_jump is asserted. Pending control flow defers the interrupt one or more cycles.
  - On take: pm_address=IRQ_VEC; pc+1 is pushed with the same overflow rules as call; in_isr=1; irq_ack pulses for 1 cycle.
  - A ret while in_isr=1 pops normally and clears in_isr.
  - irq_req is ignored while in_isr=1; no nesting.
  - Priority: just below stall.
- Undefined: irq_req and irq_ack ports are absent, and behaviour is exactly as above without interrupts.

Decomposition:
- Package seq_pkg holds:
  - enum npc_sel_t {NPC_RESET, NPC_HOLD, NPC_RET, NPC_TGT, NPC_INC, NPC_IRQ}.
  - Helper function for target formation.
- Sub-module seq_return_stack, parameterised LIFO:
  - Inputs: push, pop, din.
  - Outputs: top, sp, full, empty.
  - Overflow and underflow are flagged in the parent.

Test Plan (ADDR_W=8, TGT_W=4, STACK_DEPTH=4, RESET_VEC=0):
- Reset and increment: sync_reset held 2 cycles then released → pm_address=0 during reset; pc sequence 0,1,2,3; sp=0; both flags 0.
- Jumps: jump with jump_addr=4'hA at pc=3 → pm_address=8'hA0, next pc=8'hA0. conditional_jump, jump_addr=4'h5, dont_jump_flag=1 → pc+1. Same with dont_jump_flag=0 → 8'h50.
- Call/return: call with jump_addr=2 at pc=8'h05 → pc=8'h20, sp=1, from_PS=8'h06. ret → pc=8'h06, sp=0, from_PS=0.
- Stack faults: 5 nested calls → on the 5th, sp stays 4, stack_overflow=1, and the jump is taken. 4 rets return in LIFO order. 5th ret at pc=8'h30 → pc=8'h31, stack_underflow=1. Both flags stay 1 until reset.
- Stall and wrap: stall held 3 cycles with jump and call asserted → pc, sp and pm_address unchanged. Free-run from pc=8'hFF → 8'h00.
- IRQ (SEQ_IRQ_EN): irq_req=1 at pc=8'h12 with no control input → irq_ack pulses, pc=8'hF0, top of stack=8'h13. Second irq_req during ISR is ignored. ret → pc=8'h13, in_isr cleared. irq_req coincident with jump → jump first, interrupt taken the next cycle.
